traffic_request_scheduler: RTL
==============================

// Module: traffic_request_scheduler
// PURPOSE
//   Demand-driven scheduler in front of the 4-way traffic light controller. Latches per-direction
//   demand (N,E,S,W) and an emergency preempt, round-robins green grants, inserts all-red clearance,
//   and drives the controller's 16-bit switch word: manual-sequential while serving, auto when idle.
// PARAMETERS
//   CLK_FREQ     100_000_000  clock frequency, Hz (informational)
//   TICK_CYCLES  CLK_FREQ     clk cycles per 1 s timing tick (benches shrink this)
//   GREEN_MIN    5            minimum green hold, s, non-preempted grant
//   CLEAR_SEC    2            all-red clearance before every grant, s
//   IDLE_SEC     10           extra green with zero demand before handing back to auto, s
// PORTS
//   clk           in   1   clock
//   rst           in   1   reset, asynchronous, active-high
//   enable        in   1   0 = force auto, scheduler passive
//   req           in   4   demand pulse/level; bit0=N, bit1=E, bit2=S, bit3=W
//   emerg_valid   in   1   emergency preempt active (level)
//   emerg_dir     in   2   preempt direction: 0=N 1=E 2=S 3=W
//   switches_out  out  16  to controller switches; bit0 manual, bit1 parallel(always 0), bits2..5 N,E,S,W
//   grant         out  4   one-hot granted direction (same bit order as req), 0 when none
//   pending       out  4   latched unserved demand
//   busy          out  1   1 in CLEAR or GREEN
// BEHAVIOUR
//   Reset: state=AUTO, switches_out=0, grant=0, pending=0, busy=0, last_grant=3 (W), counters=0. All outputs registered.
//   Tick: prescaler reloaded to 0 on every state entry; sec_cnt loaded on entry, decremented per tick;
//     so a state of N s lasts exactly N*TICK_CYCLES cycles.
//   pending[i] <= (pending[i] | req[i]) & ~clr[i]; clr[i] asserts on the edge entering GREEN for i (clear wins);
//     req[i] while i is granted is ignored (treated as served).
//   States:
//     AUTO : switches_out=0, grant=0. If enable && (pending!=0 || emerg_valid) -> CLEAR (1 cycle after req).
//     CLEAR: switches_out=16'h0001 (manual, all red), grant=0, CLEAR_SEC s. On expiry select:
//            emerg_valid -> emerg_dir; else first pending bit scanning from last_grant+1 mod 4;
//            none -> AUTO. Selected -> GREEN, last_grant=sel, sec_cnt=GREEN_MIN.
//     GREEN: switches_out=16'h0001 | (1<<(2+sel)), grant=1<<sel.
//            emerg_valid && emerg_dir!=sel -> CLEAR next edge, min green aborted.
//            emerg_valid && emerg_dir==sel -> hold indefinitely, timers frozen at reload.
//            else after GREEN_MIN: pending!=0 -> CLEAR; pending==0 -> hold IDLE_SEC more, then AUTO;
//            demand arriving during idle hold -> CLEAR next edge.
//   enable low in any state: next edge -> AUTO, outputs as AUTO; pending retained and keeps latching.
//   Emergency dir change mid-GREEN is a different-dir preempt. Emergency in CLEAR waits for clearance end.
//   Only one grant bit ever set; parallel bit never set; no green without preceding CLEAR.
//   Reset mid-operation: all state/outputs to reset values immediately (async).
// TESTING  (TICK_CYCLES=10, GREEN_MIN=3, CLEAR_SEC=1, IDLE_SEC=2)
//   1 req=4'b0010 pulse 1 cycle -> pending=0010, next edge CLEAR sw=0x0001 for 10 cyc, then GREEN sw=0x0009 grant=0010 pending=0.
//   2 req=4'b0101 together after reset -> N granted first (sw=0x0005), after 30 cyc CLEAR 10 cyc, then S (sw=0x0011).
//   3 N GREEN 15 cyc in, emerg_valid=1 dir=3 -> next edge CLEAR, then W green (sw=0x0021) held while emerg_valid=1.
//   4 single req N, no further demand -> GREEN 50 cyc total then AUTO, switches_out=0, busy=0.
//   5 enable=0 mid-GREEN with pending=1000 -> next edge switches_out=0, pending stays 1000; enable=1 -> CLEAR then W.
//   6 rst asserted mid-GREEN -> switches_out=0, grant=0, pending=0 without a clock edge.

Source files
------------

// File: rtl/traffic_request_scheduler_if.sv
// traffic_request_scheduler_if: demand/preempt inputs and controller-facing outputs of the scheduler
interface traffic_request_scheduler_if;
  logic        enable;
  logic [3:0]  req;
  logic        emerg_valid;
  logic [1:0]  emerg_dir;
  logic [15:0] switches_out;
  logic [3:0]  grant;
  logic [3:0]  pending;
  logic        busy;
  modport master (
    output enable, req, emerg_valid, emerg_dir,
    input  switches_out, grant, pending, busy
  );
  modport slave (
    input  enable, req, emerg_valid, emerg_dir,
    output switches_out, grant, pending, busy
  );
endinterface

// File: rtl/traffic_request_scheduler.sv
// traffic_request_scheduler: round-robin demand scheduler with emergency preempt and all-red clearance
module traffic_request_scheduler #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int TICK_CYCLES = CLK_FREQ,
  parameter int GREEN_MIN   = 5,
  parameter int CLEAR_SEC   = 2,
  parameter int IDLE_SEC    = 10
) (
  input logic clk,
  input logic rst,
  traffic_request_scheduler_if.slave bus
);
  localparam int PW = $clog2(TICK_CYCLES + 1);
  typedef enum logic [1:0] {AUTO, CLEAR, GREEN} state_t;
  state_t          state, state_n;
  logic [PW-1:0]   pre, pre_n;
  logic [7:0]      sec, sec_n;
  logic            idle, idle_n;
  logic [1:0]      sel, sel_n, last, last_n, rr, idx;
  logic [3:0]      clr, pend_n;
  logic            tick, expire, found;
  assign tick   = pre == PW'(TICK_CYCLES - 1);
  assign expire = tick && sec == 8'd1;
  always_comb begin
    rr = last;
    idx = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && bus.pending[idx]) begin
        rr = idx;
        found = 1'b1;
      end
    end
    state_n = state;
    sel_n = sel;
    last_n = last;
    idle_n = idle;
    pre_n = tick ? '0 : pre + 1'b1;
    sec_n = tick ? sec - 1'b1 : sec;
    if (!bus.enable)
      state_n = AUTO;
    else if (state == AUTO) begin
      if (bus.pending != 4'd0 || bus.emerg_valid) begin
        state_n = CLEAR;
        pre_n = '0;
        sec_n = 8'(CLEAR_SEC);
      end
    end else if (state == CLEAR) begin
      if (expire) begin
        state_n = (bus.emerg_valid || found) ? GREEN : AUTO;
        sel_n = bus.emerg_valid ? bus.emerg_dir : rr;
        last_n = (bus.emerg_valid || found) ? sel_n : last;
        pre_n = '0;
        sec_n = 8'(GREEN_MIN);
        idle_n = 1'b0;
      end
    end else begin
      if (bus.emerg_valid && bus.emerg_dir != sel) begin
        state_n = CLEAR;
        pre_n = '0;
        sec_n = 8'(CLEAR_SEC);
      end else if (bus.emerg_valid) begin
        pre_n = '0;
        sec_n = 8'(GREEN_MIN);
        idle_n = 1'b0;
      end else if (bus.pending != 4'd0 && (idle || expire)) begin
        state_n = CLEAR;
        pre_n = '0;
        sec_n = 8'(CLEAR_SEC);
      end else if (expire) begin
        state_n = idle ? AUTO : GREEN;
        idle_n = 1'b1;
        pre_n = '0;
        sec_n = 8'(IDLE_SEC);
      end
    end
    if (state_n != GREEN)
      idle_n = 1'b0;
    if (state_n == AUTO) begin
      pre_n = '0;
      sec_n = '0;
    end
    clr = state_n == GREEN ? 4'b0001 << sel_n : 4'b0000;
    pend_n = (bus.pending | bus.req) & ~clr;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= AUTO;
      sel <= '0;
      last <= 2'd3;
      pre <= '0;
      sec <= '0;
      idle <= 1'b0;
      bus.pending <= '0;
      bus.switches_out <= '0;
      bus.grant <= '0;
      bus.busy <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      last <= last_n;
      pre <= pre_n;
      sec <= sec_n;
      idle <= idle_n;
      bus.pending <= pend_n;
      bus.switches_out <= state_n == AUTO ? 16'h0000 : state_n == CLEAR ? 16'h0001 : 16'h0001 | (16'h0004 << sel_n);
      bus.grant <= state_n == GREEN ? 4'b0001 << sel_n : 4'b0000;
      bus.busy <= state_n != AUTO;
    end
endmodule
